// File: rtl/sram_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_ctrl_if : CPU/debugger-side bus into the external SRAM controller.
//
//   sel    : SRAM region selected by the address decoder
//   addr   : byte address (bit 0 ignored by the controller)
//   r      : read request
//   w      : byte write enables, [1]=high byte, [0]=low byte
//   dwrite : write data
//   rdata  : read data, valid while ready=1 after a read
//   ready  : 1 = bus may advance, 0 = stall the CPU
//
// master : the bus mux side (drives the request)
// slave  : the controller side (returns rdata/ready)
// ---------------------------------------------------------------------------
interface sram_ctrl_if;
  logic        sel;
  logic [15:0] addr;
  logic        r;
  logic [1:0]  w;
  logic [15:0] dwrite;
  logic [15:0] rdata;
  logic        ready;

  modport master (
    output sel, addr, r, w, dwrite,
    input  rdata, ready
  );

  modport slave (
    input  sel, addr, r, w, dwrite,
    output rdata, ready
  );
endinterface

// File: rtl/sram_ctrl.sv
// ---------------------------------------------------------------------------
// sram_ctrl : synchronous controller for an external 16-bit asynchronous SRAM.
//
// Latches one bus request, sequences CE/OE/WE with programmable wait states,
// returns read data and drives ready, which stalls the CPU while an access
// is in flight.
//
// Parameters
//   WAIT_RD : cycles CE/OE held low before read data is sampled (1..15)
//   WAIT_WR : cycles WE held low per write (1..15)
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   bus          : request bus (sram_ctrl_if.slave)
//   sram_addr    : word address {3'b000, latched addr[15:1]}
//   sram_dq_i    : SRAM data bus in (tristate lives at top level)
//   sram_dq_o    : SRAM data bus out
//   sram_dq_oe   : 1 = top level drives sram_dq_o onto the bus
//   sram_*_n     : active-low SRAM strobes (registered, glitch-free)
//
// Optional feature (macro SRAM_CTRL_RDBUF_EN)
//   One-entry read buffer: a read hitting the last read word completes in
//   the request cycle without touching the SRAM. Any accepted write or a
//   reset invalidates it.
// ---------------------------------------------------------------------------
module sram_ctrl #(
  parameter int WAIT_RD = 2,
  parameter int WAIT_WR = 3
) (
  input  logic        clk,
  input  logic        reset,
  sram_ctrl_if.slave  bus,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  generate
    if (WAIT_RD < 1 || WAIT_RD > 15) begin : g_bad_wait_rd
      $error("sram_ctrl: WAIT_RD must be in 1..15");
    end
    if (WAIT_WR < 1 || WAIT_WR > 15) begin : g_bad_wait_wr
      $error("sram_ctrl: WAIT_WR must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] RD_INIT = 4'(WAIT_RD - 1);
  localparam logic [3:0] WR_INIT = 4'(WAIT_WR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD, S_WSETUP, S_WPULSE, S_WHOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [14:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [1:0]  be_q, be_d;
  logic [15:0] rdata_q, rdata_d;
  logic        ce_n_q, oe_n_q, we_n_q, ub_n_q, lb_n_q, dq_oe_q;
  logic        ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d, dq_oe_d;

  logic        req;
  logic        hit;
  logic [15:0] hit_data;
  logic        rd_last;
  logic        ready;
  logic        unused_addr0;

  assign unused_addr0 = bus.addr[0];

  // A read with w also set is still a read: r takes priority.
  assign req     = bus.sel & (bus.r | (|bus.w));
  assign rd_last = (state_q == S_RD) && (cnt_q == 4'd0);

`ifdef SRAM_CTRL_RDBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [14:0] buf_addr_q, buf_addr_d;
  logic [15:0] buf_data_q, buf_data_d;

  assign hit      = (state_q == S_IDLE) & req & bus.r & buf_valid_q &
                    (buf_addr_q == bus.addr[15:1]);
  assign hit_data = buf_data_q;

  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (rd_last) begin
      // Refill with the word just read from the SRAM.
      buf_valid_d = 1'b1;
      buf_addr_d  = addr_q;
      buf_data_d  = sram_dq_i;
    end else if ((state_q == S_IDLE) && req && !bus.r) begin
      buf_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign hit      = 1'b0;
  assign hit_data = 16'h0000;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    ready   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready = ~req | hit;
        if (req) begin
          if (hit) begin
            rdata_d = hit_data;
          end else begin
            addr_d  = bus.addr[15:1];
            wdata_d = bus.dwrite;
            be_d    = bus.w;
            if (bus.r) begin
              state_d = S_RD;
              cnt_d   = RD_INIT;
            end else begin
              state_d = S_WSETUP;
            end
          end
        end
      end
      S_RD: begin
        if (rd_last) begin
          rdata_d = sram_dq_i;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_WSETUP: begin
        state_d = S_WPULSE;
        cnt_d   = WR_INIT;
      end
      S_WPULSE: begin
        if (cnt_q == 4'd0) state_d = S_WHOLD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_WHOLD: state_d = S_DONE;
      S_DONE: begin
        ready   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state and registered, so each
    // state's pin pattern appears exactly while that state is current.
    ce_n_d  = 1'b1;
    oe_n_d  = 1'b1;
    we_n_d  = 1'b1;
    ub_n_d  = 1'b1;
    lb_n_d  = 1'b1;
    dq_oe_d = 1'b0;
    case (state_d)
      S_RD: begin
        ce_n_d = 1'b0;
        oe_n_d = 1'b0;
        ub_n_d = 1'b0;
        lb_n_d = 1'b0;
      end
      S_WSETUP, S_WPULSE, S_WHOLD: begin
        ce_n_d  = 1'b0;
        ub_n_d  = ~be_d[1];
        lb_n_d  = ~be_d[0];
        dq_oe_d = 1'b1;
        we_n_d  = (state_d != S_WPULSE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      ub_n_q  <= 1'b1;
      lb_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      ub_n_q  <= ub_n_d;
      lb_n_q  <= lb_n_d;
      dq_oe_q <= dq_oe_d;
    end
  end

  assign bus.ready  = ready;
  assign bus.rdata  = hit ? hit_data : rdata_q;
  assign sram_addr  = {3'b000, addr_q};
  assign sram_dq_o  = wdata_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_ce_n  = ce_n_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_ctrl : scoreboard bench for sram_ctrl.
//
// The driver issues bus requests and pushes the expected completion
// (latency in cycles, rdata at completion) computed from a plain word-array
// reference memory. A forked monitor measures each access on the bus,
// compares it against the queue head, and also plays the asynchronous SRAM:
// it returns data while CE/OE are low and commits a write when WE rises
// with CE still low (an access aborted by reset is not committed).
// ---------------------------------------------------------------------------
module tb_sram_ctrl;
  localparam int WAIT_RD = 2;
  localparam int WAIT_WR = 3;
`ifdef SRAM_CTRL_RDBUF_EN
  localparam bit USE_BUF = 1'b1;
`else
  localparam bit USE_BUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_ctrl_if bus();
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  sram_ctrl #(.WAIT_RD(WAIT_RD), .WAIT_WR(WAIT_WR)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  // SRAM array (physical) and reference copy (what the bench believes).
  logic [15:0] mem     [0:255];
  logic [15:0] ref_mem [0:255];
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'hDEAD;

  typedef struct {
    int          lat;
    logic [15:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  // reference-model state
  logic [15:0] last_rd;
  logic        buf_v;
  logic [14:0] buf_key;

  // monitor state
  logic        busy;
  int          lat;
  logic        prev_we_n;
  int          we_cnt;
  int          we_total;
  int          ce_total;
  logic [17:0] pend_addr;
  logic [15:0] pend_data;
  logic [1:0]  pend_lanes;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      // ---- bus side: latency and completion data
      if (reset) begin
        busy = 1'b0;
      end else begin
        if (busy) lat++;
        else if (bus.sel && (bus.r || (|bus.w))) begin
          busy = 1'b1;
          lat  = 0;
        end
        if (busy && bus.ready) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_completion actual=done expected=none t=%0t", $time);
          end else begin
            e = exp_q.pop_front();
            chk("latency", 32'(lat), 32'(e.lat));
            chk("rdata", {16'h0, bus.rdata}, {16'h0, e.rdata});
          end
          busy = 1'b0;
        end
      end
      // ---- SRAM side: pin protocol and memory behaviour
      if (!sram_ce_n) ce_total++;
      if (!sram_we_n) begin
        chk("we_ctx", {29'h0, sram_ce_n, sram_oe_n, sram_dq_oe}, 32'h3);
        if (!prev_we_n) begin
          chk("we_addr_stable", {14'h0, sram_addr}, {14'h0, pend_addr});
          chk("we_data_stable", {16'h0, sram_dq_o}, {16'h0, pend_data});
          chk("we_lane_stable", {30'h0, sram_ub_n, sram_lb_n}, {30'h0, pend_lanes});
        end
        pend_addr  = sram_addr;
        pend_data  = sram_dq_o;
        pend_lanes = {sram_ub_n, sram_lb_n};
        we_cnt++;
        we_total++;
      end else if (!prev_we_n) begin
        if (!sram_ce_n) begin
          chk("we_width", 32'(we_cnt), 32'(WAIT_WR));
          if (!pend_lanes[1]) mem[pend_addr[7:0]][15:8] = pend_data[15:8];
          if (!pend_lanes[0]) mem[pend_addr[7:0]][7:0]  = pend_data[7:0];
        end
        we_cnt = 0;
      end
      if (!sram_ce_n && !sram_oe_n)
        chk("rd_ctx", {30'h0, sram_we_n, sram_dq_oe}, 32'h2);
      prev_we_n = sram_we_n;
    end
  endtask

  task automatic scramble();
    bus.sel    = 1'b0;
    bus.r      = 1'($urandom_range(0, 1));
    bus.w      = 2'($urandom_range(0, 3));
    bus.addr   = 16'($urandom);
    bus.dwrite = 16'($urandom);
  endtask

  // Issue one access, push its expectation, hold until ready, release.
  task automatic do_access(input logic rd, input logic [1:0] we,
                           input logic [15:0] a, input logic [15:0] d);
    exp_t       e;
    logic [7:0] idx;
    bit         hit, done;
    idx = a[8:1];
    if (rd) begin
      hit     = USE_BUF && buf_v && (buf_key == a[15:1]);
      e.lat   = hit ? 0 : WAIT_RD + 1;
      last_rd = ref_mem[idx];
      buf_v   = 1'b1;
      buf_key = a[15:1];
    end else begin
      if (we[1]) ref_mem[idx][15:8] = d[15:8];
      if (we[0]) ref_mem[idx][7:0]  = d[7:0];
      buf_v = 1'b0;
      e.lat = WAIT_WR + 3;
    end
    e.rdata = last_rd;
    exp_q.push_back(e);
    $display("access rd=%0b w=%b addr=%h dwrite=%h exp_lat=%0d exp_rdata=%h",
             rd, we, a, d, e.lat, e.rdata);

    bus.sel = 1'b1; bus.r = rd; bus.w = we; bus.addr = a; bus.dwrite = d;
    done = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (bus.ready) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
      scramble();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL access_timeout actual=no_ready expected=ready addr=%h", a);
    end
    @(posedge clk); #1;
    scramble();
  endtask

  initial begin
    int ce0, we0;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    last_rd = 16'h0; buf_v = 1'b0; buf_key = '0;
    busy = 1'b0; lat = 0; prev_we_n = 1'b1; we_cnt = 0; we_total = 0; ce_total = 0;
    pend_addr = '0; pend_data = '0; pend_lanes = 2'b11;
    reset = 1'b1;
    bus.sel = 1'b0; bus.r = 1'b0; bus.w = 2'b00; bus.addr = '0; bus.dwrite = '0;
    fork
      monitor();
    join_none

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_strobes", {27'h0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1f);
    chk("rst_dq_oe", {31'h0, sram_dq_oe}, 32'h0);
    chk("rst_rdata", {16'h0, bus.rdata}, 32'h0);
    chk("rst_addr_dq", {sram_addr[15:0], sram_dq_o}, 32'h0);
    chk("rst_ready", {31'h0, bus.ready}, 32'h1);
    reset = 1'b0;
    @(posedge clk); #1;

    // full word write then read back
    do_access(1'b0, 2'b11, 16'h8002, 16'hBEEF);
    chk("wr_sram_addr", {14'h0, pend_addr}, 32'h04001);
    chk("wr_lanes_full", {30'h0, pend_lanes}, 32'h0);
    do_access(1'b1, 2'b00, 16'h8002, 16'h0000);
    chk("rd_beef", {16'h0, bus.rdata}, 32'hBEEF);

    // low byte only
    do_access(1'b0, 2'b01, 16'h8002, 16'h1234);
    chk("wr_lanes_low", {30'h0, pend_lanes}, 32'h2);
    do_access(1'b1, 2'b00, 16'h8003, 16'h0000);
    chk("rd_be34", {16'h0, bus.rdata}, 32'hBE34);

    // read and write together: read only
    we0 = we_total;
    do_access(1'b1, 2'b11, 16'h8002, 16'h5555);
    chk("rw_no_we", 32'(we_total), 32'(we0));

    // r/w without sel is not a request
    bus.sel = 1'b0; bus.r = 1'b1; bus.w = 2'b11; bus.addr = 16'h8002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nosel_idle", {29'h0, bus.ready, sram_ce_n, sram_we_n}, 32'h7);
    end
    @(posedge clk); #1;
    scramble();

    // reset in the middle of the WE pulse: no commit, strobes released
    bus.sel = 1'b1; bus.r = 1'b0; bus.w = 2'b11; bus.addr = 16'h8002; bus.dwrite = 16'hAAAA;
    @(posedge clk); #1; scramble();   // WSETUP
    @(posedge clk); #1;               // WPULSE first cycle
    @(posedge clk); #1;               // WPULSE second cycle
    chk("mid_we_low", {31'h0, sram_we_n}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_we_ce", {30'h0, sram_we_n, sram_ce_n}, 32'h3);
    chk("abort_ready", {31'h0, bus.ready}, 32'h1);
    chk("abort_rdata", {16'h0, bus.rdata}, 32'h0);
    reset = 1'b0;
    last_rd = 16'h0;
    buf_v   = 1'b0;
    @(posedge clk); #1;
    do_access(1'b1, 2'b00, 16'h8002, 16'h0000);
    chk("abort_mem_kept", {16'h0, bus.rdata}, 32'hBE34);

    // read buffer: repeat hit, then a write forces a miss
    if (USE_BUF) begin
      ce0 = ce_total;
      do_access(1'b1, 2'b00, 16'h8002, 16'h0000);
      chk("hit_no_ce", 32'(ce_total), 32'(ce0));
      do_access(1'b0, 2'b10, 16'h8010, 16'h7700);
      do_access(1'b1, 2'b00, 16'h8002, 16'h0000);
    end

    // randomized traffic over a small address window
    for (int n = 0; n < 200; n++) begin
      logic        rd;
      logic [1:0]  we;
      logic [15:0] a;
      rd = 1'($urandom_range(0, 1));
      we = rd ? 2'($urandom_range(0, 3)) : 2'($urandom_range(1, 3));
      a  = 16'h8000 | 16'($urandom_range(0, 7) << 1) | 16'($urandom_range(0, 1));
      do_access(rd, we, a, 16'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
